// File: rtl/mem_access_unit_pkg.sv
// Shared types and encodings for the MEM-stage access unit.
package mem_access_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned LT_W   = 3;
  localparam int unsigned CNT_W  = 8;

  // Load-type encodings carried on RegWriteM
  localparam logic [LT_W-1:0] LT_LB  = 3'd1;
  localparam logic [LT_W-1:0] LT_LH  = 3'd2;
  localparam logic [LT_W-1:0] LT_LW  = 3'd3;
  localparam logic [LT_W-1:0] LT_LBU = 3'd4;
  localparam logic [LT_W-1:0] LT_LHU = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Halfword/word accesses must be naturally aligned; unknown load types behave as LW
  function automatic logic is_misaligned(input logic            store,
                                         input logic [BE_W-1:0] mask,
                                         input logic [LT_W-1:0] lt,
                                         input logic [1:0]      off);
    logic mis;
    mis = 1'b0;
    if (store) begin
      if (mask == 4'b1111)      mis = (off != 2'b00);
      else if (mask == 4'b0011) mis = off[0];
    end else begin
      case (lt)
        LT_LB, LT_LBU: mis = 1'b0;
        LT_LH, LT_LHU: mis = off[0];
        default:       mis = (off != 2'b00);
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Combinational byte-lane shift and sign/zero extension of a read word.
module load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [LT_W-1:0]   lt,
  output logic [DATA_W-1:0] data_c
);

  logic [DATA_W-1:0] w;

  // Bring the addressed byte/halfword down to bit 0, then extend by load type
  always_comb begin
    w = rdata >> {off, 3'b000};
    case (lt)
      LT_LB:   data_c = {{24{w[7]}}, w[7:0]};
      LT_LBU:  data_c = {24'd0, w[7:0]};
      LT_LH:   data_c = {{16{w[15]}}, w[15:0]};
      LT_LHU:  data_c = {16'd0, w[15:0]};
      default: data_c = w;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: req/ack handshake, store alignment,
// load extension, timeout abort and pipeline stall generation.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] AluOutM,
  input  logic [DATA_W-1:0] StoreDataM,
  input  logic [BE_W-1:0]   MemWriteM,
  input  logic              MemToRegM,
  input  logic [LT_W-1:0]   RegWriteM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] LoadDataM,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              timeout_o
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          off_q, off_d;
  logic [LT_W-1:0]     lt_q, lt_d;
  logic                isld_q, isld_d;
  logic                req_d, we_d, mis_d, to_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [BE_W-1:0]     be_d;
  logic [DATA_W-1:0]   wdata_d, ld_d, ext_c;
  logic                acc_c, store_c, mis_c;

  // Extension uses the copies latched at request time, not the live inputs
  load_ext u_load_ext (
    .rdata  (mem_rdata),
    .off    (off_q),
    .lt     (lt_q),
    .data_c (ext_c)
  );

  // Access decode and hazard-unit stall
  always_comb begin
    store_c = |MemWriteM;
    acc_c   = MemToRegM | store_c;
    mis_c   = is_misaligned(store_c, MemWriteM, RegWriteM, AluOutM[1:0]);
    stall_o = acc_c & ~mis_c & (state_q != RESP);
  end

  // Next-state and next register values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    lt_d    = lt_q;
    isld_d  = isld_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    be_d    = mem_be;
    wdata_d = mem_wdata;
    ld_d    = LoadDataM;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_c) begin
          if (mis_c) begin
            mis_d = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = store_c;
            addr_d  = {AluOutM[31:2], 2'b00};
            be_d    = store_c ? (MemWriteM << AluOutM[1:0]) : '0;
            wdata_d = StoreDataM << {AluOutM[1:0], 3'b000};
            off_d   = AluOutM[1:0];
            lt_d    = RegWriteM;
            isld_d  = ~store_c;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          if (isld_q) ld_d = ext_c;
          req_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          if (isld_q) ld_d = '0;
          to_d    = 1'b1;
          req_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      lt_q       <= '0;
      isld_q     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      LoadDataM  <= '0;
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      lt_q       <= lt_d;
      isld_q     <= isld_d;
      mem_req    <= req_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_be     <= be_d;
      mem_wdata  <= wdata_d;
      LoadDataM  <= ld_d;
      misalign_o <= mis_d;
      timeout_o  <= to_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (default TIMEOUT plus a TIMEOUT=4 instance).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] AluOutM, StoreDataM, mem_rdata;
  logic [3:0]  MemWriteM;
  logic        MemToRegM, mem_ack;
  logic [2:0]  RegWriteM;
  logic        mem_req, mem_we, stall_o, misalign_o, timeout_o;
  logic [31:0] mem_addr, mem_wdata, LoadDataM;
  logic [3:0]  mem_be;

  logic [31:0] t_addr, t_rdata;
  logic        t_mtr, t_ack;
  logic [2:0]  t_rw;
  logic        t_req, t_we, t_stall, t_mis, t_to;
  logic [31:0] t_maddr, t_wdata, t_ld;
  logic [3:0]  t_be;

  int n_cmp = 0;
  int n_mis = 0;
  int stall_cnt, req_cnt, addr_bad;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .AluOutM(AluOutM), .StoreDataM(StoreDataM),
    .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .LoadDataM(LoadDataM), .stall_o(stall_o), .misalign_o(misalign_o),
    .timeout_o(timeout_o)
  );

  mem_access_unit #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .AluOutM(t_addr), .StoreDataM(32'd0),
    .MemWriteM(4'd0), .MemToRegM(t_mtr), .RegWriteM(t_rw),
    .mem_req(t_req), .mem_we(t_we), .mem_addr(t_maddr), .mem_be(t_be),
    .mem_wdata(t_wdata), .mem_rdata(t_rdata), .mem_ack(t_ack),
    .LoadDataM(t_ld), .stall_o(t_stall), .misalign_o(t_mis),
    .timeout_o(t_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load on the main instance, ending back in IDLE with inputs idle
  task automatic load_zw(input logic [31:0] addr, input logic [2:0] rw, input logic [31:0] rd);
    AluOutM = addr; MemToRegM = 1'b1; RegWriteM = rw;
    tick();
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0; MemToRegM = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    AluOutM = '0; StoreDataM = '0; MemWriteM = '0; MemToRegM = 1'b0;
    RegWriteM = '0; mem_rdata = '0; mem_ack = 1'b0;
    t_addr = '0; t_rdata = '0; t_mtr = 1'b0; t_ack = 1'b0; t_rw = '0;
    #12;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_ld", LoadDataM, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: zero-wait LW
    AluOutM = 32'h100; MemToRegM = 1'b1; RegWriteM = 3'd3;
    #1;
    chk("t1_stall_idle", {31'd0, stall_o}, 32'd1);
    tick();
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_we", {31'd0, mem_we}, 32'd0);
    chk("t1_stall_busy", {31'd0, stall_o}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t1_ld", LoadDataM, 32'hDEADBEEF);
    chk("t1_stall_resp", {31'd0, stall_o}, 32'd0);
    chk("t1_req_resp", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0; MemToRegM = 1'b0;
    tick();

    // 2: byte/halfword extension
    load_zw(32'h103, 3'd1, 32'h80112233);
    chk("t2_lb", LoadDataM, 32'hFFFFFF80);
    load_zw(32'h103, 3'd4, 32'h80112233);
    chk("t2_lbu", LoadDataM, 32'h00000080);
    load_zw(32'h102, 3'd2, 32'h80112233);
    chk("t2_lh", LoadDataM, 32'hFFFF8011);

    // 3: SB to 0x201
    AluOutM = 32'h201; StoreDataM = 32'hAB; MemWriteM = 4'b0001;
    tick();
    chk("t3_be", {28'd0, mem_be}, 32'h2);
    chk("t3_wdata", mem_wdata, 32'h0000AB00);
    chk("t3_addr", mem_addr, 32'h200);
    chk("t3_we", {31'd0, mem_we}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    tick();
    chk("t3_ld_kept", LoadDataM, 32'hFFFF8011);
    mem_ack = 1'b0; MemWriteM = 4'b0000; StoreDataM = '0;
    tick();

    // 4: LW with ack in the 5th BUSY cycle
    AluOutM = 32'h104; MemToRegM = 1'b1; RegWriteM = 3'd3;
    #1;
    stall_cnt = int'(stall_o); req_cnt = 0; addr_bad = 0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      stall_cnt += int'(stall_o);
      req_cnt   += int'(mem_req);
      if (mem_addr !== 32'h104) addr_bad++;
      if (i == 5) begin mem_ack = 1'b1; mem_rdata = 32'h12345678; end
      tick();
    end
    mem_ack = 1'b0;
    stall_cnt += int'(stall_o);
    chk("t4_stall_cycles", 32'(stall_cnt), 32'd6);
    chk("t4_req_cycles", 32'(req_cnt), 32'd5);
    chk("t4_addr_stable", 32'(addr_bad), 32'd0);
    chk("t4_ld", LoadDataM, 32'h12345678);
    chk("t4_no_timeout", {31'd0, timeout_o}, 32'd0);
    MemToRegM = 1'b0;
    tick();
    chk("t4_req_idle", {31'd0, mem_req}, 32'd0);

    // 5: TIMEOUT=4 instance, preload then abort
    t_addr = 32'h100; t_mtr = 1'b1; t_rw = 3'd3;
    tick();
    t_ack = 1'b1; t_rdata = 32'hCAFEF00D;
    tick();
    chk("t5_preload", t_ld, 32'hCAFEF00D);
    t_ack = 1'b0; t_mtr = 1'b0;
    tick();
    t_mtr = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t5_req_4th", {31'd0, t_req}, 32'd1);
    chk("t5_to_early", {31'd0, t_to}, 32'd0);
    tick();
    chk("t5_to_pulse", {31'd0, t_to}, 32'd1);
    chk("t5_ld_zero", t_ld, 32'd0);
    chk("t5_req_drop", {31'd0, t_req}, 32'd0);
    chk("t5_stall_resp", {31'd0, t_stall}, 32'd0);
    t_mtr = 1'b0;
    tick();
    chk("t5_to_clear", {31'd0, t_to}, 32'd0);

    // 6: misaligned LW from 0x102
    AluOutM = 32'h102; MemToRegM = 1'b1; RegWriteM = 3'd3;
    #1;
    chk("t6_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("t6_mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("t6_no_req", {31'd0, mem_req}, 32'd0);
    MemToRegM = 1'b0;
    tick();
    chk("t6_mis_clear", {31'd0, misalign_o}, 32'd0);
    chk("t6_no_req2", {31'd0, mem_req}, 32'd0);

    // Reset mid-BUSY, then a late ack
    AluOutM = 32'h100; MemToRegM = 1'b1; RegWriteM = 3'd3;
    tick();
    chk("r_req_busy", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("r_req_async", {31'd0, mem_req}, 32'd0);
    MemToRegM = 1'b0;
    #1;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    chk("r_late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("r_late_ack_ld", LoadDataM, 32'd0);
    mem_ack = 1'b0;
    tick();

    // Recovery: LHU after reset
    load_zw(32'h102, 3'd5, 32'h80112233);
    chk("r_lhu", LoadDataM, 32'h00008011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
